// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Memory stage plus the Memory/Writeback pipeline register of a 32-bit
// in-order core. The M-stage address selects a word in an internal
// synchronous data RAM. Stores write through byte enables. Every enabled
// cycle the addressed word is read into a read-data register, so the loaded
// word lines up with the instruction in W. The W stage selects the load
// lane, applies sign or zero extension and muxes the final writeback value.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (priority over en)
//   en          advance enable; low = stall (hold W state, suppress store)
//   RegWriteM   M-stage instruction writes the register file
//   MemWriteM   M-stage instruction is a store
//   ResultSrcM  00 ALU result, 01 load data, 10 PCPlus4, 11 zero
//   funct3M     access size [1:0] and unsigned-load flag [2]
//   RdM         destination register
//   ALUResultM  byte address / ALU result
//   WriteDataM  store data (low bits used for SB/SH)
//   PCPlus4M    return address
//   RegWriteW   register file write enable (dropped on misaligned access)
//   RdW         destination register
//   ResultW     writeback value
//   MisalignW   W-stage instruction was a misaligned memory access
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  RegWriteM,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            funct3M,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic                  RegWriteW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic                  MisalignW
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IDX_W;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Select the addressed lane of a loaded word and extend it to 32 bits.
  // A halfword always comes from the half chosen by lane[1], so a
  // misaligned halfword still yields a defined (if meaningless) value.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = word[8*lane +: 8];
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   res_v = f3[2] ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   res_v = f3[2] ? {16'h0000, half_v}   : {{16{half_v[15]}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  // ------------------------------------------------------------------------
  // M-stage decode
  // ------------------------------------------------------------------------
  logic [IDX_W-1:0]      w_index;
  logic [1:0]            w_lane;
  logic [1:0]            w_size;
  logic                  w_mem_access;
  logic                  w_bad_align;
  logic                  w_misalign;
  logic [DATA_WIDTH-1:0] w_store_data;
  logic [3:0]            w_byte_en;
  logic                  w_store_en;

  // Upper address bits are ignored, so addresses alias modulo the RAM size.
  assign w_index = ALUResultM[ADDR_WIDTH-1:2];
  assign w_lane  = ALUResultM[1:0];

  // Access size: byte, halfword, otherwise word.
  always_comb begin
    w_size = SZ_WORD;
    case (funct3M[1:0])
      2'b00:   w_size = SZ_BYTE;
      2'b01:   w_size = SZ_HALF;
      default: w_size = SZ_WORD;
    endcase
  end

  // Misalignment only matters for instructions that actually touch memory.
  always_comb begin
    w_bad_align = 1'b0;
    case (w_size)
      SZ_HALF: w_bad_align = w_lane[0];
      SZ_WORD: w_bad_align = (w_lane != 2'b00);
      default: w_bad_align = 1'b0;
    endcase
  end

  assign w_mem_access = MemWriteM | (ResultSrcM == SRC_LOAD);
  assign w_misalign   = w_mem_access & w_bad_align;

  // Replicate store data across lanes so the byte enables alone pick the target.
  always_comb begin
    w_store_data = WriteDataM;
    w_byte_en    = 4'b1111;
    case (w_size)
      SZ_BYTE: begin
        w_store_data = {4{WriteDataM[7:0]}};
        w_byte_en    = 4'b0001 << w_lane;
      end
      SZ_HALF: begin
        w_store_data = {2{WriteDataM[15:0]}};
        w_byte_en    = 4'b0011 << w_lane;
      end
      default: begin
        w_store_data = WriteDataM;
        w_byte_en    = 4'b1111;
      end
    endcase
  end

  // Stores are dropped during reset, during a stall and when misaligned.
  assign w_store_en = MemWriteM & en & ~rst & ~w_misalign;

  // ------------------------------------------------------------------------
  // Data RAM (contents are never reset)
  // ------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-enabled RAM write at the edge closing the M cycle.
  always_ff @(posedge clk) begin
    if (w_store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_index][8*b +: 8] <= w_store_data[8*b +: 8];
        end
      end
    end
  end

  // Read-first synchronous read: a same-edge write is not seen by this read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else if (en) begin
      r_rdata <= r_mem[w_index];
    end
  end

  // ------------------------------------------------------------------------
  // Memory/Writeback register
  // ------------------------------------------------------------------------
  logic                  r_reg_write_w;
  logic [4:0]            r_rd_w;
  logic [1:0]            r_result_src_w;
  logic [2:0]            r_funct3_w;
  logic [1:0]            r_lane_w;
  logic [DATA_WIDTH-1:0] r_alu_result_w;
  logic [DATA_WIDTH-1:0] r_pc_plus4_w;
  logic                  r_misalign_w;

  // W-stage capture; a misaligned access never writes the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write_w  <= 1'b0;
      r_rd_w         <= 5'd0;
      r_result_src_w <= 2'b00;
      r_funct3_w     <= 3'b000;
      r_lane_w       <= 2'b00;
      r_alu_result_w <= {DATA_WIDTH{1'b0}};
      r_pc_plus4_w   <= {DATA_WIDTH{1'b0}};
      r_misalign_w   <= 1'b0;
    end else if (en) begin
      r_reg_write_w  <= RegWriteM & ~w_misalign;
      r_rd_w         <= RdM;
      r_result_src_w <= ResultSrcM;
      r_funct3_w     <= funct3M;
      r_lane_w       <= w_lane;
      r_alu_result_w <= ALUResultM;
      r_pc_plus4_w   <= PCPlus4M;
      r_misalign_w   <= w_misalign;
    end
  end

  // ------------------------------------------------------------------------
  // Writeback value
  // ------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_load_value;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_load_value = load_extend(r_rdata, r_lane_w, r_funct3_w);

  // Writeback source select.
  always_comb begin
    w_result = {DATA_WIDTH{1'b0}};
    case (r_result_src_w)
      SRC_ALU:  w_result = r_alu_result_w;
      SRC_LOAD: w_result = w_load_value;
      SRC_PC4:  w_result = r_pc_plus4_w;
      default:  w_result = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign RegWriteW = r_reg_write_w;
  assign RdW       = r_rd_w;
  assign ResultW   = w_result;
  assign MisalignW = r_misalign_w;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, en, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        RegWriteW, MisalignW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: byte-addressed memory and expected W-stage outputs.
  logic [7:0]  mem_m [0:4095];
  logic [31:0] exp_result;
  logic        exp_regw, exp_mis;
  logic [4:0]  exp_rd;

  mem_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .en(en), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  // Present one M-stage instruction, advance the model, clock once and
  // return 1 time unit after the edge.
  task automatic issue(input logic r, input logic e, input logic rw, input logic mw,
                       input logic [1:0] rs, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc4);
    int size, ai, base;
    logic mis;
    logic [31:0] raw, ld;
    rst = r; en = e; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    funct3M = f3; RdM = rd; ALUResultM = addr; WriteDataM = wd; PCPlus4M = pc4;
    if (r) begin
      exp_result = 32'h0; exp_regw = 1'b0; exp_mis = 1'b0; exp_rd = 5'd0;
    end else if (e) begin
      size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
      ai   = int'(addr[11:0]);
      base = ai - (ai % size);
      raw  = 32'h0;
      for (int k = 0; k < size; k++) raw[8*k +: 8] = mem_m[base + k];
      if (size == 1)      ld = f3[2] ? raw : {{24{raw[7]}}, raw[7:0]};
      else if (size == 2) ld = f3[2] ? raw : {{16{raw[15]}}, raw[15:0]};
      else                ld = raw;
      mis = (mw || rs == 2'b01) && (ai % size != 0);
      case (rs)
        2'b00:   exp_result = addr;
        2'b01:   exp_result = ld;
        2'b10:   exp_result = pc4;
        default: exp_result = 32'h0;
      endcase
      exp_regw = rw && !mis;
      exp_rd   = rd;
      exp_mis  = mis;
      if (mw && !mis) begin
        for (int k = 0; k < size; k++) mem_m[ai + k] = wd[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_init();
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010, 5'd0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++)
      issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'(4 * i), 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h020, 32'h11223344, 32'h0);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd7, 32'h020, 32'hDEADBEEF, 32'h44);
    n_vec++;
    if (RegWriteW !== 1'b0 || ResultW !== 32'h0 || MisalignW !== 1'b0 || RdW !== 5'd0) begin
      n_miss++;
      $display("FAIL reset_outputs: got regw=%b res=%h mis=%b rd=%0d, want 0/0/0/0",
               RegWriteW, ResultW, MisalignW, RdW);
    end
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd3, 32'h020, 32'h0, 32'h0);
    n_vec++;
    if (ResultW !== 32'h11223344 || ResultW !== exp_result) begin
      n_miss++;
      $display("FAIL reset_store_suppressed: got %h, want 11223344", ResultW);
    end
  endtask

  task automatic test_sw_loads();
    logic [2:0]  f3s  [4] = '{3'b010, 3'b000, 3'b100, 3'b001};
    logic [31:0] adrs [4] = '{32'h010, 32'h013, 32'h013, 32'h012};
    logic [31:0] want [4] = '{32'h87654321, 32'hFFFFFF87, 32'h00000087, 32'hFFFF8765};
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h010, 32'h87654321, 32'h0);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, f3s[i], 5'd10, adrs[i], 32'h0, 32'h0);
      n_vec++;
      if (ResultW !== want[i] || RegWriteW !== 1'b1 || RdW !== 5'd10) begin
        n_miss++;
        $display("FAIL sw_load_%0d: got res=%h regw=%b rd=%0d, want res=%h regw=1 rd=10",
                 i, ResultW, RegWriteW, RdW, want[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h010, 32'h00000000, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 5'd0, 32'h011, 32'h123456AA, 32'h0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd4, 32'h010, 32'h0, 32'h0);
    n_vec++;
    if (ResultW !== 32'h0000AA00) begin
      n_miss++;
      $display("FAIL sb_lane1: got %h, want 0000aa00", ResultW);
    end
  endtask

  task automatic test_read_first();
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h014, 32'hCAFEF00D, 32'h0);
    issue(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd6, 32'h014, 32'h0BADBEEF, 32'h0);
    n_vec++;
    if (ResultW !== 32'hCAFEF00D) begin
      n_miss++;
      $display("FAIL read_first_old: got %h, want cafef00d", ResultW);
    end
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd6, 32'h014, 32'h0, 32'h0);
    n_vec++;
    if (ResultW !== 32'h0BADBEEF) begin
      n_miss++;
      $display("FAIL read_first_new: got %h, want 0badbeef", ResultW);
    end
  endtask

  task automatic test_misaligned();
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h010, 32'h01020304, 32'h0);
    issue(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 3'b001, 5'd8, 32'h013, 32'h0000FFFF, 32'h0);
    n_vec++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin
      n_miss++;
      $display("FAIL misalign_sh: got mis=%b regw=%b, want mis=1 regw=0", MisalignW, RegWriteW);
    end
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd8, 32'h012, 32'h0, 32'h0);
    n_vec++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin
      n_miss++;
      $display("FAIL misalign_lw: got mis=%b regw=%b, want mis=1 regw=0", MisalignW, RegWriteW);
    end
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd8, 32'h010, 32'h0, 32'h0);
    n_vec++;
    if (ResultW !== 32'h01020304 || MisalignW !== 1'b0 || RegWriteW !== 1'b1) begin
      n_miss++;
      $display("FAIL misalign_ram_unchanged: got res=%h mis=%b regw=%b, want 01020304/0/1",
               ResultW, MisalignW, RegWriteW);
    end
  endtask

  task automatic test_stall();
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h010, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 1'(i[0]), 1'b1, 2'(i), 3'b010, 5'(20 + i), 32'h010,
            32'hFFFFFFFF, 32'h200);
      n_vec++;
      if (ResultW !== 32'h01020304 || RdW !== 5'd9 || RegWriteW !== 1'b1) begin
        n_miss++;
        $display("FAIL stall_hold_%0d: got res=%h rd=%0d regw=%b, want 01020304/9/1",
                 i, ResultW, RdW, RegWriteW);
      end
    end
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h010, 32'h0, 32'h0);
    n_vec++;
    if (ResultW !== 32'h01020304) begin
      n_miss++;
      $display("FAIL stall_no_store: got %h, want 01020304", ResultW);
    end
  endtask

  task automatic test_mux_wrap();
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b010, 5'd1, 32'h0000_0FFF, 32'h0, 32'h104);
    n_vec++;
    if (ResultW !== 32'h104) begin
      n_miss++;
      $display("FAIL mux_pc4: got %h, want 00000104", ResultW);
    end
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b010, 5'd1, 32'h12345677, 32'h0, 32'h104);
    n_vec++;
    if (ResultW !== 32'h12345677 || MisalignW !== 1'b0) begin
      n_miss++;
      $display("FAIL mux_alu: got res=%h mis=%b, want 12345677/0", ResultW, MisalignW);
    end
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 3'b010, 5'd1, 32'h12345678, 32'h0, 32'h104);
    n_vec++;
    if (ResultW !== 32'h0) begin
      n_miss++;
      $display("FAIL mux_zero: got %h, want 00000000", ResultW);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h1010, 32'h13579BDF, 32'h0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd2, 32'h010, 32'h0, 32'h0);
    n_vec++;
    if (ResultW !== 32'h13579BDF) begin
      n_miss++;
      $display("FAIL wrap_alias: got %h, want 13579bdf", ResultW);
    end
  endtask

  task automatic test_random();
    logic [31:0] rnd;
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      issue(1'b0 + ($urandom_range(0, 39) == 0), 1'b0 + ($urandom_range(0, 3) != 0),
            1'($urandom), 1'b0 + ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom), rnd & 32'hFFFF_F03F, $urandom, $urandom);
      n_vec++;
      if (ResultW !== exp_result || RegWriteW !== exp_regw || RdW !== exp_rd ||
          MisalignW !== exp_mis) begin
        n_miss++;
        $display("FAIL random_%0d: got res=%h regw=%b rd=%0d mis=%b, want res=%h regw=%b rd=%0d mis=%b",
                 i, ResultW, RegWriteW, RdW, MisalignW, exp_result, exp_regw, exp_rd, exp_mis);
      end
    end
  endtask

  initial begin
    test_init();
    test_reset();
    test_sw_loads();
    test_partial_store();
    test_read_first();
    test_misaligned();
    test_stall();
    test_mux_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-stage consumer of the Execute/Memory pipeline register outputs, plus the Memory/Writeback register. Takes the M-stage address (ALUResultM), store data (WriteDataM) and PCPlus4M with their control bits. Performs byte/half/word stores into an internal synchronous data RAM and issues the matching load. It registers everything into the W stage and produces the final writeback value with load lane selection and sign/zero extension.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- ADDR_WIDTH, 12, byte-address bits used; RAM depth is 2^(ADDR_WIDTH-2) words.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  advance enable; low = stall (hold W state, suppress store).
- RegWriteM  input  1  instruction writes the register file.
- MemWriteM  input  1  store instruction.
- ResultSrcM  input  2  00 ALU result, 01 load data, 10 PCPlus4.
- funct3M  input  3  access size/sign.
- RdM  input  5  destination register.
- ALUResultM  input  DATA_WIDTH  byte address / ALU result.
- WriteDataM  input  DATA_WIDTH  store data (low bits used for SB/SH).
- PCPlus4M  input  DATA_WIDTH  return address.
- RegWriteW  output  1  register file write enable.
- RdW  output  5  destination register.
- ResultW  output  DATA_WIDTH  writeback value.
- MisalignW  output  1  W-stage instruction was a misaligned access.

## Operation
- Address: word index = ALUResultM[ADDR_WIDTH-1:2]; lane = ALUResultM[1:0]. Higher bits are ignored, so addresses wrap modulo RAM size.
- Access size for loads and stores:
  - funct3[1:0] = 00: byte.
  - funct3[1:0] = 01: halfword.
  - Otherwise: word.
- Extension for loads: funct3[2] = 1 means zero-extend (LBU/LHU); otherwise sign-extend.
- Misaligned access:
  - Halfword with addr[0] = 1, or word with addr[1:0] != 00.
  - Applies only when MemWriteM = 1 or ResultSrcM = 01.
- Store (MemWriteM = 1, en = 1, aligned):
  - Data is replicated across lanes: byte to all 4 lanes, half to both halves.
  - Byte enables: SB = 0001 << lane; SH = 0011 << lane; SW = 1111.
  - The RAM is written at the closing edge of the M cycle.
- Misaligned store: no RAM write.
- Load: the RAM reads the word index synchronously every enabled cycle. The RAM is read-first, so a same-edge write is not visible to that read.
- W registers, loaded when en = 1: RegWriteW, RdW, ResultSrcW, funct3W, lane, ALUResultW, PCPlus4W, MisalignW.
  - RegWriteW is forced to 0 when the access is misaligned.
- ResultW mux, combinational in W:
  - 00: ALUResultW.
  - 01: extended load lane.
  - 10: PCPlus4W.
  - 11: 0.
- Load lane selection: byte = word[8*lane +: 8]; half = word[16*lane[1] +: 16]; word = whole word.
- en = 0:
  - All W registers hold.
  - The RAM read-data register holds, so ResultW stays stable.
  - No store occurs.
- rst = 1:
  - All W registers clear, so RegWriteW = 0, RdW = 0, MisalignW = 0, ResultW = 0.
  - The read-data register clears.
  - RAM contents are not cleared.
  - A store presented in the reset cycle is suppressed.
- rst has priority over en.

## Timing
- Store: committed at the rising edge ending the M cycle. A load in the next M cycle to the same address returns the new data.
- Load latency: ResultW is valid one cycle after the instruction is presented in M, i.e. in its W cycle.
- ALU/PCPlus4 results: also one cycle M→W.
- MisalignW: asserted for exactly the one W cycle of the offending instruction, or longer if stalled.
- Reset mid-stream: the first enabled cycle after rst falls captures the current M inputs normally.

## Test plan
- Reset: assert rst with MemWriteM = 1, then read the same address → RAM unchanged; RegWriteW = 0, ResultW = 0 and MisalignW = 0 during reset.
- SW then loads:
  - Stimulus: SW 0x8765_4321 to 0x010; then LW, LB lane 3, LBU lane 3 and LH lane 2.
  - Required: ResultW = 0x87654321, 0xFFFFFF87, 0x00000087 and 0xFFFF8765 respectively, each one cycle later.
- Partial store, same-edge read:
  - Stimulus: SB 0xAA to 0x011 over 0x00000000, then LW 0x010.
  - Required: 0x0000AA00.
  - Read-first check: a load to 0x014 issued in the same cycle as an SW to 0x014 returns the old word.
- Misaligned:
  - Stimulus: SH to 0x013 and LW from 0x012.
  - Required: RAM unchanged, MisalignW = 1, RegWriteW = 0 for that W cycle.
- Stall: load 0x010 then hold en = 0 for 3 cycles while M inputs change → ResultW, RdW and RegWriteW are held constant, and no store from the stalled M inputs occurs.
- Mux and wrap:
  - ResultSrc = 10 with PCPlus4M = 0x104 → ResultW = 0x104.
  - Address 0x1010 with ADDR_WIDTH = 12 aliases to 0x010.
